// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter in front of a NUM_REGS x WIDTH register bank.
// Optional lock feature: define REG_ARB_LOCK_EN to add req_lock, the LOCK state and the lock counter.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 3,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
`ifdef REG_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REGS-1:0]       wr_sel,
    output logic [WIDTH-1:0]          wr_data,
    output logic                      err,
    output logic                      busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;

    state_t               state, nxt_state;
    logic [PW-1:0]        rr_ptr, win;
    logic [NUM_REQ-1:0]   elig;
    logic                 hit, bad;
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH-1:0]     data;
    logic [NUM_REGS-1:0]  sel;

`ifdef REG_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [PW-1:0] owner, nxt_owner;
    logic [CW-1:0] lock_cnt, nxt_cnt;
    logic          hold;
    assign hold = state == LOCK && req[owner] && req_lock[owner];
`endif

    always_comb begin
`ifdef REG_ARB_LOCK_EN
        elig = req & ~gnt & (hold ? NUM_REQ'(1) << owner : '1);
`else
        elig = req & ~gnt;
`endif
        hit = 1'b0;
        win = '0;
        // Descending scan so the lowest offset from rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
                hit = 1'b1;
                win = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
        addr = req_addr[win*ADDR_W +: ADDR_W];
        data = req_data[win*WIDTH +: WIDTH];
        bad  = 32'(addr) >= NUM_REGS;
        sel  = bad ? '0 : NUM_REGS'(1) << addr;
`ifdef REG_ARB_LOCK_EN
        nxt_owner = owner;
        nxt_cnt   = '0;
        nxt_state = hit ? GRANT : IDLE;
        if (hold) begin
            nxt_cnt   = hit ? lock_cnt + 1'b1 : lock_cnt;
            nxt_state = LOCK;
            if (hit && lock_cnt + 1'b1 == CW'(LOCK_MAX)) begin
                nxt_cnt   = '0;
                nxt_state = GRANT;
            end
        end else if (hit && req_lock[win] && LOCK_MAX > 1) begin
            nxt_owner = win;
            nxt_cnt   = CW'(1);
            nxt_state = LOCK;
        end
`else
        nxt_state = hit ? GRANT : IDLE;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt     <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
            rr_ptr  <= '0;
`ifdef REG_ARB_LOCK_EN
            owner    <= '0;
            lock_cnt <= '0;
`endif
        end else begin
            gnt     <= hit ? NUM_REQ'(1) << win : '0;
            wr_sel  <= hit ? sel : '0;
            wr_data <= hit ? data : '0;
            err     <= hit && bad;
            busy    <= nxt_state != IDLE;
            state   <= nxt_state;
            // Under lock the winner is always the owner, so this keeps rr_ptr at owner+1.
            if (hit)
                rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef REG_ARB_LOCK_EN
            owner    <= nxt_owner;
            lock_cnt <= nxt_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed vectors for reg_write_arbiter (NUM_REGS=6, LOCK_MAX=4).
// The lock scenario runs only when REG_ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] req_addr = '0;
    logic [127:0] req_data = '0;
    logic [3:0]  req_lock = 4'b0000;
    logic [3:0]  gnt;
    logic [5:0]  wr_sel;
    logic [31:0] wr_data;
    logic        err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    reg_write_arbiter #(
        .NUM_REQ(4), .NUM_REGS(6), .WIDTH(32), .ADDR_W(3), .LOCK_MAX(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
`ifdef REG_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .gnt(gnt),
        .wr_sel(wr_sel),
        .wr_data(wr_data),
        .err(err),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [5:0] s, input logic [31:0] d);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".sel"}, 32'(wr_sel), 32'(s));
        chk({tag, ".data"}, wr_data, d);
    endtask

    initial begin
        logic [3:0]  g3 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [5:0]  s3 [5] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h01};
        logic [31:0] d3 [5] = '{32'd10, 32'd32, 32'd55, 32'd0, 32'd10};
        // Reset held with all requests high
        req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out("rst", 4'b0000, 6'h00, 32'd0);
            chk("rst.err", 32'(err), 32'd0);
            chk("rst.busy", 32'(busy), 32'd0);
        end
        // Lone requester 0, addr 2, data 10
        req = 4'b0001;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd2};
        req_data = {32'd0, 32'd55, 32'd32, 32'd10};
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) chk_out("lone.g", 4'b0001, 6'h04, 32'd10);
            else chk_out("lone.z", 4'b0000, 6'h00, 32'd0);
        end
        req = 4'b0000;
        step();
        chk("lone.busy", 32'(busy), 32'd0);
        // Async reset pulse between edges, then all four requesters
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b1111;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("rr%0d", i), g3[i], s3[i], d3[i]);
        end
        step();
        chk_out("rr5", 4'b0010, 6'h02, 32'd32);
        chk("rr5.busy", 32'(busy), 32'd1);
        // Async reset mid-stream clears outputs before the next edge
        #2;
        reset = 1'b1;
        #1;
        chk_out("arst", 4'b0000, 6'h00, 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        step();
        chk_out("arst.hold", 4'b0000, 6'h00, 32'd0);
        #2;
        reset = 1'b0;
        step();
        chk_out("arst.first", 4'b0001, 6'h01, 32'd10);
        // Out-of-range address 6 on requester 1
        req = 4'b0010;
        req_addr = {3'd3, 3'd2, 3'd6, 3'd0};
        step();
        chk("oor.gnt", 32'(gnt), 32'b0010);
        chk("oor.sel", 32'(wr_sel), 32'd0);
        chk("oor.err", 32'(err), 32'd1);
        req = 4'b0000;
        step();
        chk("oor.err1", 32'(err), 32'd0);
        chk("oor.gnt1", 32'(gnt), 32'd0);
        step();
        chk("oor.busy", 32'(busy), 32'd0);
`ifdef REG_ARB_LOCK_EN
        // Lock: req0 locked with req2 pending, LOCK_MAX=4
        reset = 1'b1;
        #2;
        reset = 1'b0;
        req = 4'b0101;
        req_lock = 4'b0001;
        req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("lock%0d", i), 32'(gnt), (i % 2 == 0) ? 32'b0001 : 32'b0000);
            chk($sformatf("lock%0d.busy", i), 32'(busy), 32'd1);
        end
        step();
        chk("lock.rel", 32'(gnt), 32'b0100);
        chk("lock.data", wr_data, 32'd55);
        chk("lock.ptr", 32'(dut.rr_ptr), 32'd3);
        req = 4'b0000;
        req_lock = 4'b0000;
        step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
